// File: rtl/mac_layer_ctrl_pkg.sv
// Shared Q8.8 fixed-point constants and FSM state encoding for the NN layer controllers.
package nn_pkg;

    localparam int Q_DW   = 16;
    localparam int Q_FRAC = 8;

    localparam logic [Q_DW-1:0] Q_MAX = 16'h7FFF;
    localparam logic [Q_DW-1:0] Q_MIN = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_WAIT,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_t;

    // Address widths never collapse to zero bits, even for single-entry memories.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_layer_ctrl_if.sv
// Bundle of scheduler handshake, operand memories, MAC datapath and output buffer signals.
interface mac_layer_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = 16
);
    import nn_pkg::*;

    localparam int XAW = addr_width(N_IN);
    localparam int WAW = addr_width(N_IN * N_OUT);
    localparam int BAW = addr_width(N_OUT);

    logic           start;
    logic           busy;
    logic           done;
    logic           err;
    logic [XAW-1:0] x_addr;
    logic [DW-1:0]  x_data;
    logic [WAW-1:0] w_addr;
    logic [DW-1:0]  w_data;
    logic [BAW-1:0] b_addr;
    logic [DW-1:0]  b_data;
    logic           mac_start;
    logic [DW-1:0]  mac_x;
    logic [DW-1:0]  mac_w;
    logic [DW-1:0]  mac_acc;
    logic           mac_done;
    logic           y_we;
    logic [BAW-1:0] y_addr;
    logic [DW-1:0]  y_data;

    modport master (
        input  start, x_data, w_data, b_data, mac_acc, mac_done,
        output busy, done, err, x_addr, w_addr, b_addr,
               mac_start, mac_x, mac_w, y_we, y_addr, y_data
    );

    modport slave (
        output start, x_data, w_data, b_data, mac_acc, mac_done,
        input  busy, done, err, x_addr, w_addr, b_addr,
               mac_start, mac_x, mac_w, y_we, y_addr, y_data
    );

endinterface

// File: rtl/mac_layer_ctrl_q8_sat_add.sv
// Combinational saturating signed adder; with MAC_LAYER_RELU_EN defined, negative results clamp to zero.
module q8_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [W:0]   sum;
    logic [W-1:0] sat;

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    always_comb begin
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            sat = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat = sum[W-1:0];
        end
`ifdef MAC_LAYER_RELU_EN
        y = sat[W-1] ? '0 : sat;
`else
        y = sat;
`endif
    end

endmodule

// File: rtl/mac_layer_ctrl.sv
// Sequences one shared MAC through a fully-connected layer: fetch, stream, wait, bias, write.
// Optional ReLU in the bias stage is selected with MAC_LAYER_RELU_EN.
module mac_layer_ctrl #(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 4,
    parameter int DW          = 16,
    parameter int MAC_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst_n,
    mac_layer_ctrl_if.master bus
);
    import nn_pkg::*;

    localparam int XAW = addr_width(N_IN);
    localparam int WAW = addr_width(N_IN * N_OUT);
    localparam int BAW = addr_width(N_OUT);
    localparam int TW  = addr_width(MAC_TIMEOUT + 1);

    localparam logic [XAW-1:0] LAST_I = XAW'(N_IN - 1);
    localparam logic [BAW-1:0] LAST_J = BAW'(N_OUT - 1);
    localparam logic [TW-1:0]  T_MAX  = TW'(MAC_TIMEOUT);

    state_t         state, state_n;
    logic [XAW-1:0] i_q, i_n;
    logic [BAW-1:0] j_q, j_n;
    logic [TW-1:0]  t_q, t_n;
    logic           err_q, err_n;
    logic [DW-1:0]  acc_q, acc_n;
    logic [DW-1:0]  res_q, res_n;
    logic [DW-1:0]  sat_y;

    q8_sat_add #(.W(DW)) u_sat (
        .a(acc_q),
        .b(bus.b_data),
        .y(sat_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            i_q   <= '0;
            j_q   <= '0;
            t_q   <= '0;
            err_q <= 1'b0;
            acc_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            i_q   <= i_n;
            j_q   <= j_n;
            t_q   <= t_n;
            err_q <= err_n;
            acc_q <= acc_n;
            res_q <= res_n;
        end
    end

    // Memory addresses lead their data by one cycle, so STREAM always issues pair i+1.
    always_comb begin
        state_n       = state;
        i_n           = i_q;
        j_n           = j_q;
        t_n           = t_q;
        err_n         = err_q;
        acc_n         = acc_q;
        res_n         = res_q;
        bus.x_addr    = '0;
        bus.w_addr    = '0;
        bus.mac_start = 1'b0;
        bus.mac_x     = '0;
        bus.mac_w     = '0;
        bus.y_we      = 1'b0;
        bus.y_addr    = '0;
        bus.done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    j_n     = '0;
                    err_n   = 1'b0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.w_addr = WAW'(int'(j_q) * N_IN);
                i_n        = '0;
                state_n    = S_STREAM;
            end
            S_STREAM: begin
                bus.mac_x     = bus.x_data;
                bus.mac_w     = bus.w_data;
                bus.mac_start = (i_q == '0);
                if (i_q == LAST_I) begin
                    t_n     = TW'(1);
                    state_n = S_WAIT;
                end else begin
                    bus.x_addr = XAW'(int'(i_q) + 1);
                    bus.w_addr = WAW'(int'(j_q) * N_IN + int'(i_q) + 1);
                    i_n        = i_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mac_done) begin
                    acc_n   = bus.mac_acc;
                    state_n = S_BIAS;
                end else if (t_q == T_MAX) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    t_n = t_q + 1'b1;
                end
            end
            S_BIAS: begin
                res_n   = sat_y;
                state_n = S_WRITE;
            end
            S_WRITE: begin
                bus.y_we   = 1'b1;
                bus.y_addr = j_q;
                if (j_q == LAST_J) begin
                    state_n = S_DONE;
                end else begin
                    j_n     = j_q + 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bias address is simply the current neuron; its data is stable long before BIAS.
    assign bus.b_addr = j_q;
    assign bus.busy   = (state != S_IDLE);
    assign bus.err    = err_q;
    assign bus.y_data = res_q;

endmodule

// File: tb/tb_mac_layer_ctrl.sv
// Table-driven bench for mac_layer_ctrl with memory and latency-programmable MAC models.
module tb_mac_layer_ctrl;
    import nn_pkg::*;

    localparam int N_IN        = 4;
    localparam int N_OUT       = 4;
    localparam int DW          = 16;
    localparam int MAC_TIMEOUT = 16;

`ifdef MAC_LAYER_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] w [N_IN];
        logic [DW-1:0] b;
        logic          frc;
        logic [DW-1:0] facc;
        logic [DW-1:0] exp_y;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mac_layer_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

    mac_layer_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .MAC_TIMEOUT(MAC_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    vec_t          vecs [2*N_OUT];
    logic [DW-1:0] xl [2][N_IN];
    logic [DW-1:0] xmem [N_IN];
    logic [DW-1:0] wmem [N_IN*N_OUT];
    logic [DW-1:0] bmem [N_OUT];
    logic          frc [N_OUT];
    logic [DW-1:0] facc [N_OUT];

    int n_tests = 0;
    int n_fail  = 0;
    int mac_lat = 2;
    bit mac_en  = 1'b1;
    bit force_done = 1'b0;

    // Synchronous-read memories: one cycle from address to data.
    always @(posedge clk) begin
        bus.x_data <= xmem[bus.x_addr];
        bus.w_data <= wmem[bus.w_addr];
        bus.b_data <= bmem[bus.b_addr];
    end

    // MAC model: full-precision accumulate, Q8.8 result, mac_done mac_lat cycles after the last pair.
    int acc, cnt, dly, cur_j, prod;
    always_comb prod = int'($signed(bus.mac_x)) * int'($signed(bus.mac_w));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 0; cnt <= 0; dly <= 0; cur_j <= 0;
        end else begin
            if (dly != 0) dly <= dly - 1;
            if (bus.mac_start) begin
                acc   <= prod;
                cnt   <= 1;
                cur_j <= int'(bus.w_addr) / N_IN;
            end else if (cnt > 0 && cnt < N_IN) begin
                acc <= acc + prod;
                cnt <= cnt + 1;
                if (cnt == N_IN - 1 && mac_en) dly <= mac_lat;
            end
        end
    end

    assign bus.mac_acc  = frc[cur_j] ? facc[cur_j] : 16'(acc >>> 8);
    assign bus.mac_done = (dly == 1) || force_done;

    int            wr_total = 0, done_total = 0, busy_total = 0, ms_total = 0;
    int            cap_addr [64];
    logic [DW-1:0] cap_data [64];

    always @(negedge clk) begin
        if (bus.y_we) begin
            if (wr_total < 64) begin
                cap_addr[wr_total] = int'(bus.y_addr);
                cap_data[wr_total] = bus.y_data;
            end
            wr_total = wr_total + 1;
        end
        if (bus.done)      done_total = done_total + 1;
        if (bus.busy)      busy_total = busy_total + 1;
        if (bus.mac_start) ms_total   = ms_total + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setVec(input int idx, input logic [DW-1:0] w0, w1, w2, w3,
                          input logic [DW-1:0] b, input logic f, input logic [DW-1:0] fa,
                          input logic [DW-1:0] ey);
        vecs[idx].w[0] = w0; vecs[idx].w[1] = w1;
        vecs[idx].w[2] = w2; vecs[idx].w[3] = w3;
        vecs[idx].b = b; vecs[idx].frc = f; vecs[idx].facc = fa; vecs[idx].exp_y = ey;
    endtask

    task automatic applyStimulus(input int layer, input int lat, input bit en);
        for (int i = 0; i < N_IN; i++) xmem[i] = xl[layer][i];
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) wmem[j*N_IN+i] = vecs[layer*N_OUT+j].w[i];
            bmem[j] = vecs[layer*N_OUT+j].b;
            frc[j]  = vecs[layer*N_OUT+j].frc;
            facc[j] = vecs[layer*N_OUT+j].facc;
        end
        mac_lat   = lat;
        mac_en    = en;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input bit poke);
        int k = 0;
        while (done_total == d0 && k < 400) begin
            tick();
            k++;
        end
        checkOutput("done_seen", 32'(done_total > d0), 1);
        if (poke) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            checkOutput("start_at_done_busy", 32'(bus.busy), 0);
        end
        tick();
        checkOutput("idle_after_done", 32'(bus.busy), 0);
    endtask

    task automatic checkLayer(input string tag, input int layer, input int w0, d0, b0, exp_busy);
        checkOutput({tag, "_writes"}, wr_total - w0, N_OUT);
        checkOutput({tag, "_dones"}, done_total - d0, 1);
        checkOutput({tag, "_err"}, 32'(bus.err), 0);
        checkOutput({tag, "_latency"}, busy_total - b0, exp_busy);
        for (int k = 0; k < N_OUT; k++) begin
            checkOutput($sformatf("%s_addr%0d", tag, k), cap_addr[w0+k], k);
            checkOutput($sformatf("%s_y%0d", tag, k), 32'(cap_data[w0+k]),
                        32'(vecs[layer*N_OUT+k].exp_y));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, d0, b0, m0, k;
        xl[0] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        xl[1] = '{16'h0100, 16'hFF00, 16'h0200, 16'hFE00};
        setVec(0, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 0, 16'h0000, 16'h0500);
        setVec(1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 16'h0000, 16'h0B00);
        setVec(2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 1, 16'h7F00, Q_MAX);
        setVec(3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFE00, 1, 16'h8100,
               RELU ? 16'h0000 : Q_MIN);
        setVec(4, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0040, 0, 16'h0000, 16'h0040);
        setVec(5, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFF00, 0, 16'h0000,
               RELU ? 16'h0000 : 16'hFF00);
        setVec(6, 16'h0200, 16'h0100, 16'h0100, 16'h0080, 16'h0000, 0, 16'h0000, 16'h0200);
        setVec(7, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 0, 16'h0000,
               RELU ? 16'h0000 : 16'hFF80);
        for (int j = 0; j < N_OUT; j++) begin frc[j] = 1'b0; facc[j] = '0; end

        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_err", 32'(bus.err), 0);
        checkOutput("rst_y_we", 32'(bus.y_we), 0);
        checkOutput("rst_y_data", 32'(bus.y_data), 0);
        checkOutput("rst_mac_start", 32'(bus.mac_start), 0);
        checkOutput("rst_addrs", {bus.x_addr, bus.w_addr, bus.b_addr}, 0);
        rst_n = 1'b1;
        tick();

        // Nominal layer, MAC latency 2 -> W=2.
        w0 = wr_total; d0 = done_total; b0 = busy_total;
        applyStimulus(0, 2, 1'b1);
        waitDone(d0, 1'b0);
        checkLayer("nomA", 0, w0, d0, b0, N_OUT*(N_IN+3+2)+1);

        // mac_done while idle must not start anything.
        w0 = wr_total;
        force_done = 1'b1;
        repeat (3) tick();
        force_done = 1'b0;
        checkOutput("idle_done_busy", 32'(bus.busy), 0);
        checkOutput("idle_done_writes", wr_total - w0, 0);

        // Signed cancellation, W=1, start coincident with done.
        w0 = wr_total; d0 = done_total; b0 = busy_total;
        applyStimulus(1, 1, 1'b1);
        waitDone(d0, 1'b1);
        checkLayer("cancB", 1, w0, d0, b0, N_OUT*(N_IN+3+1)+1);

        // start pulsed during neuron 1 streaming is ignored.
        w0 = wr_total; d0 = done_total; b0 = busy_total; m0 = ms_total;
        applyStimulus(0, 2, 1'b1);
        k = 0;
        while (ms_total - m0 < 2 && k < 100) begin tick(); k++; end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        waitDone(d0, 1'b0);
        checkLayer("midstart", 0, w0, d0, b0, N_OUT*(N_IN+3+2)+1);
        checkOutput("midstart_mac_starts", ms_total - m0, N_OUT);

        // MAC never answers: timeout after MAC_TIMEOUT wait cycles.
        w0 = wr_total; d0 = done_total; b0 = busy_total;
        applyStimulus(0, 2, 1'b0);
        waitDone(d0, 1'b0);
        checkOutput("tmo_err", 32'(bus.err), 1);
        checkOutput("tmo_writes", wr_total - w0, 0);
        checkOutput("tmo_dones", done_total - d0, 1);
        checkOutput("tmo_latency", busy_total - b0, 1 + N_IN + MAC_TIMEOUT + 1);
        tick();
        checkOutput("tmo_err_sticky", 32'(bus.err), 1);

        w0 = wr_total; d0 = done_total; b0 = busy_total;
        applyStimulus(0, 2, 1'b1);
        checkOutput("restart_err_clr", 32'(bus.err), 0);
        waitDone(d0, 1'b0);
        checkLayer("restart", 0, w0, d0, b0, N_OUT*(N_IN+3+2)+1);

        // Reset during neuron 2 WAIT aborts without done.
        d0 = done_total; m0 = ms_total;
        applyStimulus(1, 3, 1'b1);
        k = 0;
        while (ms_total - m0 < 3 && k < 100) begin tick(); k++; end
        repeat (N_IN) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_outs", {bus.done, bus.y_we, bus.mac_start, bus.err}, 0);
        checkOutput("abort_addrs", {bus.x_addr, bus.w_addr, bus.b_addr, bus.y_addr}, 0);
        checkOutput("abort_y_data", 32'(bus.y_data), 0);
        checkOutput("abort_mac_x", 32'(bus.mac_x), 0);
        repeat (3) tick();
        checkOutput("abort_no_done", done_total - d0, 0);
        rst_n = 1'b1;
        tick();

        w0 = wr_total; d0 = done_total; b0 = busy_total;
        applyStimulus(1, 1, 1'b1);
        waitDone(d0, 1'b0);
        checkLayer("postrst", 1, w0, d0, b0, N_OUT*(N_IN+3+1)+1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
